// File: rtl/bht_update_unit.sv
// Branch history table: 2-bit saturating counters per entry, trained by
// resolved conditional branches through a one-entry write pipeline with
// forwarding, self-initialised after reset and on flush.
module bht_update_unit #(
    parameter int unsigned NR_ENTRIES = 64,
    parameter int unsigned VLEN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    output logic            lookup_valid_o,
    output logic            lookup_taken_o,
    output logic [1:0]      lookup_counter_o,
    input  logic            resolve_valid_i,
    input  logic [VLEN-1:0] resolve_pc_i,
    input  logic            resolve_conditional_i,
    input  logic            resolve_taken_i,
    output logic            init_done_o
);

    localparam int unsigned INDEX_W = $clog2(NR_ENTRIES);
    localparam logic [1:0]  CNT_INIT = 2'b01;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [INDEX_W-1:0]   r_ptr;
    logic                 r_pend_valid;
    logic [INDEX_W-1:0]   r_pend_idx;
    logic [1:0]           r_pend_cnt;
    logic [1:0]           r_cnt [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] r_vld;

    logic [INDEX_W-1:0]   w_lk_idx;
    logic                 w_lk_hit;
    logic                 w_lk_vld;
    logic [1:0]           w_lk_cnt;
    logic [INDEX_W-1:0]   w_rs_idx;
    logic [1:0]           w_rs_eff;
    logic [1:0]           w_rs_new;
    logic                 w_accept;
    logic                 w_run;
    logic                 w_unused;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    assign w_run    = (r_state == ST_RUN);
    assign w_lk_idx = vpc_i[INDEX_W:1];
    assign w_rs_idx = resolve_pc_i[INDEX_W:1];

    // Lookup path with forwarding from the pending write
    always_comb begin
        w_lk_hit = r_pend_valid && (r_pend_idx == w_lk_idx);
        w_lk_vld = w_lk_hit | r_vld[w_lk_idx];
        w_lk_cnt = w_lk_hit ? r_pend_cnt : r_cnt[w_lk_idx];
    end

    assign lookup_valid_o   = w_run & w_lk_vld;
    assign lookup_counter_o = lookup_valid_o ? w_lk_cnt : 2'b00;
    assign lookup_taken_o   = lookup_counter_o[1];
    assign init_done_o      = w_run;

    // Resolve path: effective counter (forwarded) and its trained value
    always_comb begin
        w_rs_eff = (r_pend_valid && (r_pend_idx == w_rs_idx)) ? r_pend_cnt : r_cnt[w_rs_idx];
        w_rs_new = resolve_taken_i ? sat_inc(w_rs_eff) : sat_dec(w_rs_eff);
        w_accept = w_run & resolve_valid_i & resolve_conditional_i & ~debug_mode_i & ~flush_i;
    end

    // Control: INIT/RUN state, init pointer and pending update register
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state      <= ST_INIT;
            r_ptr        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_cnt   <= CNT_INIT;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ptr        <= r_ptr + INDEX_W'(1);
                    r_pend_valid <= 1'b0;
                    if (r_ptr == INDEX_W'(NR_ENTRIES - 1)) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_pend_valid <= w_accept;
                    if (w_accept) begin
                        r_pend_idx <= w_rs_idx;
                        r_pend_cnt <= w_rs_new;
                    end
                end
            endcase
        end
    end

    // Table storage: init sweep writes, otherwise commit of the pending update
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (r_state == ST_INIT) begin
                r_cnt[r_ptr] <= CNT_INIT;
                r_vld[r_ptr] <= 1'b0;
            end else if (r_pend_valid) begin
                r_cnt[r_pend_idx] <= r_pend_cnt;
                r_vld[r_pend_idx] <= 1'b1;
            end
        end
    end

    assign w_unused = ^{vpc_i[VLEN-1:INDEX_W+1], vpc_i[0],
                        resolve_pc_i[VLEN-1:INDEX_W+1], resolve_pc_i[0]};

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed self-checking bench for bht_update_unit.
module tb_bht_update_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        debug_mode_i;
    logic [31:0] vpc_i;
    logic        lookup_valid_o;
    logic        lookup_taken_o;
    logic [1:0]  lookup_counter_o;
    logic        resolve_valid_i;
    logic [31:0] resolve_pc_i;
    logic        resolve_conditional_i;
    logic        resolve_taken_i;
    logic        init_done_o;

    int n_checks = 0;
    int n_pass   = 0;

    bht_update_unit #(.NR_ENTRIES(64), .VLEN(32)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_i               (flush_i),
        .debug_mode_i          (debug_mode_i),
        .vpc_i                 (vpc_i),
        .lookup_valid_o        (lookup_valid_o),
        .lookup_taken_o        (lookup_taken_o),
        .lookup_counter_o      (lookup_counter_o),
        .resolve_valid_i       (resolve_valid_i),
        .resolve_pc_i          (resolve_pc_i),
        .resolve_conditional_i (resolve_conditional_i),
        .resolve_taken_i       (resolve_taken_i),
        .init_done_o           (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one active edge and settle on the following negedge
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic v, input logic [1:0] c);
        vpc_i = pc;
        #1;
        check({tag, ".valid"}, 32'(lookup_valid_o), 32'(v));
        check({tag, ".cnt"},   32'(lookup_counter_o), 32'(c));
        check({tag, ".taken"}, 32'(lookup_taken_o), 32'(c[1]));
    endtask

    task automatic resolve(input logic v, input logic [31:0] pc,
                           input logic cond, input logic tk);
        resolve_valid_i       = v;
        resolve_pc_i          = pc;
        resolve_conditional_i = cond;
        resolve_taken_i       = tk;
    endtask

    // Count the INIT window: low after 63 edges, high after the 64th
    task automatic init_window(input string tag);
        for (int i = 0; i < 63; i++) step();
        #1 check({tag, ".done63"}, 32'(init_done_o), 32'd0);
        step();
        #1 check({tag, ".done64"}, 32'(init_done_o), 32'd1);
    endtask

    logic [1:0] chain_exp [7];

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0; vpc_i = '0;
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        step();
        #1 check("rst.done", 32'(init_done_o), 32'd0);
        lookup("rst.lk", 32'h8000_0010, 1'b0, 2'b00);
        rst_i = 1'b0;
        init_window("init");
        lookup("run.lk_fresh", 32'h8000_0010, 1'b0, 2'b00);

        // Single taken update: forwarded next cycle, then committed
        resolve(1'b1, 32'h8000_0010, 1'b1, 1'b1);
        step();
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        lookup("one.fwd", 32'h8000_0010, 1'b1, 2'b10);
        lookup("one.neighbour", 32'h8000_0012, 1'b0, 2'b00);
        step();
        lookup("one.commit", 32'h8000_0010, 1'b1, 2'b10);
        lookup("alias", 32'h0000_0090, 1'b1, 2'b10);

        // Back-to-back chain to one index, both saturation ends
        chain_exp[0] = 2'b10; chain_exp[1] = 2'b11; chain_exp[2] = 2'b11;
        chain_exp[3] = 2'b10; chain_exp[4] = 2'b01; chain_exp[5] = 2'b00;
        chain_exp[6] = 2'b00;
        vpc_i = 32'h20;
        for (int k = 0; k < 7; k++) begin
            resolve(1'b1, 32'h20, 1'b1, (k < 3));
            step();
            lookup($sformatf("chain%0d", k), 32'h20, 1'b1, chain_exp[k]);
        end
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        lookup("chain.commit", 32'h20, 1'b1, 2'b00);

        // Ignored reports: debug mode and non-conditional
        debug_mode_i = 1'b1;
        resolve(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        debug_mode_i = 1'b0;
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        lookup("debug", 32'h40, 1'b0, 2'b00);
        resolve(1'b1, 32'h40, 1'b0, 1'b1);
        step();
        resolve(1'b1, 32'h20, 1'b0, 1'b1);
        step();
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        lookup("nocond.new", 32'h40, 1'b0, 2'b00);
        lookup("nocond.old", 32'h20, 1'b1, 2'b00);

        // Flush with coincident resolve, plus a re-flush mid-INIT
        flush_i = 1'b1;
        resolve(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        flush_i = 1'b0;
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("flush.done", 32'(init_done_o), 32'd0);
        lookup("flush.lk_init", 32'h8000_0010, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        init_window("reflush");
        lookup("flush.idx8", 32'h8000_0010, 1'b0, 2'b00);
        lookup("flush.idx16", 32'h20, 1'b0, 2'b00);
        lookup("flush.dropped", 32'h40, 1'b0, 2'b00);
        resolve(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        lookup("flush.first", 32'h40, 1'b1, 2'b10);
        resolve(1'b1, 32'h42, 1'b1, 1'b0);
        step();
        resolve(1'b0, 32'h0, 1'b0, 1'b0);
        lookup("flush.first_nt", 32'h42, 1'b1, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
